// File: rtl/gpu_regfile_pkg.sv
// gpu_regfile_pkg: shared constants and writeback types for the register-file write port.
// Rev 1.0
`default_nettype none

package gpu_regfile_pkg;

  localparam int DEF_NUM_REQ      = 4;
  localparam int DEF_DATA_WIDTH   = 32;
  localparam int DEF_NUM_REGS     = 16;
  localparam int DEF_ADDR_WIDTH   = $clog2(DEF_NUM_REGS);
  localparam int DEF_REQ_ID_WIDTH = $clog2(DEF_NUM_REQ);

  typedef struct packed {
    logic [DEF_ADDR_WIDTH-1:0] addr;
    logic [DEF_DATA_WIDTH-1:0] data;
  } wb_req_t;

  typedef struct packed {
    logic                        valid;
    logic [DEF_ADDR_WIDTH-1:0]   addr;
    logic [DEF_DATA_WIDTH-1:0]   data;
    logic [DEF_REQ_ID_WIDTH-1:0] src;
  } wb_stage_t;

endpackage

`default_nettype wire

// File: rtl/gpu_regfile_wb_arbiter_rr.sv
// gpu_rr_arbiter: combinational round-robin pick, searching upward from last_grant+1 with wrap.
// Rev 1.0
`default_nettype none

module gpu_rr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int IDX_WIDTH = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]   req,
  input  logic [IDX_WIDTH-1:0] last_grant,
  output logic [NUM_REQ-1:0]   grant,
  output logic [IDX_WIDTH-1:0] grant_idx,
  output logic                 grant_valid
);

  logic [31:0]          cand;
  logic [IDX_WIDTH-1:0] sel;

  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    cand        = '0;
    sel         = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = (32'(last_grant) + 32'(i)) % 32'(NUM_REQ);
      sel  = IDX_WIDTH'(cand);
      if (!grant_valid && req[sel]) begin
        grant_valid = 1'b1;
        grant[sel]  = 1'b1;
        grant_idx   = sel;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/gpu_regfile_wb_arbiter.sv
// gpu_regfile_wb_arbiter: round-robin sharing of the register-file write port through a one-entry issue stage.
// Rev 1.0
`default_nettype none

module gpu_regfile_wb_arbiter
  import gpu_regfile_pkg::*;
#(
  parameter int NUM_REQ      = DEF_NUM_REQ,
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int NUM_REGS     = DEF_NUM_REGS,
  parameter int ADDR_WIDTH   = $clog2(NUM_REGS),
  parameter int REQ_ID_WIDTH = $clog2(NUM_REQ)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             i_req_valid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]  i_req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  i_req_data,
  output logic [NUM_REQ-1:0]             o_req_ready,
  input  logic                           i_stall,
  output logic                           o_wr_en,
  output logic [ADDR_WIDTH-1:0]          o_wr_addr,
  output logic [DATA_WIDTH-1:0]          o_wr_data,
  output logic [REQ_ID_WIDTH-1:0]        o_wr_src,
  output logic [NUM_REGS-1:0]            o_pending_mask
);

  wb_req_t                 reqs [NUM_REQ];
  wb_stage_t               stage;
  logic [REQ_ID_WIDTH-1:0] last_grant;
  logic [REQ_ID_WIDTH-1:0] grant_idx;
  logic [NUM_REQ-1:0]      grant;
  logic                    grant_valid;
  logic                    can_accept;
  logic                    handshake;

  generate
    for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
      assign reqs[k] = {i_req_addr[k*ADDR_WIDTH +: ADDR_WIDTH],
                        i_req_data[k*DATA_WIDTH +: DATA_WIDTH]};
    end
  endgenerate

  gpu_rr_arbiter #(
    .NUM_REQ   (NUM_REQ),
    .IDX_WIDTH (REQ_ID_WIDTH)
  ) u_arb (
    .req         (i_req_valid),
    .last_grant  (last_grant),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  // Ready is held low throughout reset so nothing is accepted into a discarded stage.
  assign can_accept  = rst_n & (~stage.valid | ~i_stall);
  assign o_req_ready = grant & {NUM_REQ{can_accept}};
  assign handshake   = grant_valid & can_accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage      <= '0;
      last_grant <= REQ_ID_WIDTH'(NUM_REQ - 1);
    end else if (handshake) begin
      stage.valid <= 1'b1;
      stage.addr  <= reqs[grant_idx].addr;
      stage.data  <= reqs[grant_idx].data;
      stage.src   <= grant_idx;
      last_grant  <= grant_idx;
    end else if (!i_stall) begin
      stage.valid <= 1'b0;
    end
  end

  always_comb begin
    o_pending_mask             = '0;
    o_pending_mask[stage.addr] = stage.valid;
  end

  assign o_wr_en   = stage.valid & ~i_stall;
  assign o_wr_addr = stage.addr;
  assign o_wr_data = stage.data;
  assign o_wr_src  = stage.src;

endmodule

`default_nettype wire

// File: tb/tb_gpu_regfile_wb_arbiter.sv
// tb_gpu_regfile_wb_arbiter: scenario tasks plus randomized traffic against a queue-based reference model.
// Rev 1.0
`default_nettype none

module tb_gpu_regfile_wb_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int NR = 16;
  localparam int AW = 4;
  localparam int IW = 2;
  localparam int VW = N + 1 + AW + DW + IW + NR;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*DW-1:0] req_data = '0;
  logic [N-1:0]    req_ready;
  logic            stall = 1'b0;
  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [DW-1:0]   wr_data;
  logic [IW-1:0]   wr_src;
  logic [NR-1:0]   pending_mask;

  always #5 clk = ~clk;

  gpu_regfile_wb_arbiter #(
    .NUM_REQ    (N),
    .DATA_WIDTH (DW),
    .NUM_REGS   (NR)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_req_valid    (req_valid),
    .i_req_addr     (req_addr),
    .i_req_data     (req_data),
    .o_req_ready    (req_ready),
    .i_stall        (stall),
    .o_wr_en        (wr_en),
    .o_wr_addr      (wr_addr),
    .o_wr_data      (wr_data),
    .o_wr_src       (wr_src),
    .o_pending_mask (pending_mask)
  );

  // Stimulus held by the requesters
  logic [N-1:0]  v_valid = '0;
  logic [AW-1:0] v_addr [N];
  logic [DW-1:0] v_data [N];
  logic          v_stall = 1'b0;

  // Observed and predicted values for the current cycle
  logic [N-1:0]  act_ready, exp_ready, hs_mask;
  logic          act_wr_en, exp_wr_en;
  logic [AW-1:0] act_addr, exp_addr;
  logic [DW-1:0] act_data, exp_data;
  logic [IW-1:0] act_src, exp_src;
  logic [NR-1:0] act_mask, exp_mask;
  logic [VW-1:0] act_vec, exp_vec;

  // Reference model: pointer, in-flight queue, last loaded entry, register file
  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            src;
  } ent_t;

  int            m_ptr = N - 1;
  ent_t          m_q[$];
  ent_t          m_hold = '{addr: '0, data: '0, src: 0};
  logic [DW-1:0] m_rf   [NR];
  logic [DW-1:0] dut_rf [NR];
  int            dut_log_src[$];
  logic [DW-1:0] dut_log_data[$];

  int total = 0;
  int bad   = 0;

  function automatic int model_winner();
    for (int i = 1; i <= N; i++) begin
      if (v_valid[(m_ptr + i) % N]) return (m_ptr + i) % N;
    end
    return -1;
  endfunction

  function automatic int onehot_idx(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_ptr  = N - 1;
    m_hold = '{addr: '0, data: '0, src: 0};
  endtask

  task automatic renew();
    for (int k = 0; k < N; k++) begin
      if (hs_mask[k]) begin
        v_addr[k] = AW'($urandom_range(0, NR - 1));
        v_data[k] = $urandom;
      end
    end
  endtask

  // One clock: drive at the falling edge, sample 1ns later, advance models at the rising edge.
  task automatic cycle();
    int w;
    @(negedge clk);
    req_valid = v_valid;
    stall     = v_stall;
    for (int k = 0; k < N; k++) begin
      req_addr[k*AW +: AW] = v_addr[k];
      req_data[k*DW +: DW] = v_data[k];
    end
    #1;
    act_ready = req_ready;
    act_wr_en = wr_en;
    act_addr  = wr_addr;
    act_data  = wr_data;
    act_src   = wr_src;
    act_mask  = pending_mask;
    w = model_winner();
    exp_ready = '0;
    if (w >= 0 && (m_q.size() == 0 || !v_stall)) exp_ready[w] = 1'b1;
    exp_wr_en = (m_q.size() != 0) && !v_stall;
    exp_addr  = m_hold.addr;
    exp_data  = m_hold.data;
    exp_src   = IW'(m_hold.src);
    exp_mask  = '0;
    if (m_q.size() != 0) exp_mask[m_q[0].addr] = 1'b1;
    act_vec = {act_ready, act_wr_en, act_addr, act_data, act_src, act_mask};
    exp_vec = {exp_ready, exp_wr_en, exp_addr, exp_data, exp_src, exp_mask};
    hs_mask = exp_ready & v_valid;
    @(posedge clk);
    if (act_wr_en) begin
      dut_rf[act_addr] = act_data;
      dut_log_src.push_back(int'(act_src));
      dut_log_data.push_back(act_data);
    end
    if (exp_wr_en) begin
      m_rf[m_q[0].addr] = m_q[0].data;
      void'(m_q.pop_front());
    end
    if (|exp_ready) begin
      m_hold = '{addr: v_addr[w], data: v_data[w], src: w};
      m_q.push_back(m_hold);
      m_ptr = w;
    end
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    v_valid = '0;
    v_stall = 1'b0;
    for (int k = 0; k < N; k++) begin
      v_addr[k] = '0;
      v_data[k] = '0;
    end
    repeat (2) @(negedge clk);
    #1;
    total++;
    if ({req_ready, wr_en, wr_addr, wr_data, wr_src, pending_mask} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got %h want 0",
               {req_ready, wr_en, wr_addr, wr_data, wr_src, pending_mask});
    end
    @(negedge clk);
    req_valid = '1;
    #1;
    total++;
    if (req_ready !== '0) begin
      bad++;
      $display("FAIL reset_ready: got %b want 0000", req_ready);
    end
    req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    cycle();
    total++;
    if ({act_ready, act_wr_en, act_mask} !== '0) begin
      bad++;
      $display("FAIL idle: got %h want 0", {act_ready, act_wr_en, act_mask});
    end
    v_valid   = 4'b0010;
    v_addr[1] = 4'd3;
    v_data[1] = 32'hDEADBEEF;
    cycle();
    total++;
    if (act_ready !== 4'b0010) begin
      bad++;
      $display("FAIL single_ready: got %b want 0010", act_ready);
    end
    v_valid = '0;
    cycle();
    total++;
    if ({act_wr_en, act_addr, act_data, act_src, act_mask} !==
        {1'b1, 4'd3, 32'hDEADBEEF, 2'd1, 16'h0008}) begin
      bad++;
      $display("FAIL single_write: got en=%b a=%0d d=%h s=%0d m=%h want en=1 a=3 d=deadbeef s=1 m=0008",
               act_wr_en, act_addr, act_data, act_src, act_mask);
    end
    cycle();
    total++;
    if (act_vec !== exp_vec) begin
      bad++;
      $display("FAIL single_drain: got %h want %h", act_vec, exp_vec);
    end
  endtask

  task automatic test_back_to_back();
    int prev = -1;
    int idx;
    v_valid = '1;
    for (int k = 0; k < N; k++) begin
      v_addr[k] = AW'($urandom_range(0, NR - 1));
      v_data[k] = $urandom;
    end
    for (int c = 0; c < 10; c++) begin
      cycle();
      idx = onehot_idx(act_ready);
      total++;
      if (act_vec !== exp_vec) begin
        bad++;
        $display("FAIL b2b_model c%0d: got %h want %h", c, act_vec, exp_vec);
      end
      if (c > 0) begin
        total++;
        if (!act_wr_en || idx != (prev + 1) % N || !$onehot(act_ready)) begin
          bad++;
          $display("FAIL b2b_rr c%0d: got en=%b grant=%0d want en=1 grant=%0d",
                   c, act_wr_en, idx, (prev + 1) % N);
        end
      end
      prev = idx;
      renew();
    end
  endtask

  task automatic test_stall();
    logic [AW-1:0] cap_addr;
    logic [DW-1:0] cap_data;
    logic [IW-1:0] cap_src;
    logic [NR-1:0] cap_mask;
    cycle();
    renew();
    v_stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      cycle();
      if (c == 0) begin
        cap_addr = act_addr;
        cap_data = act_data;
        cap_src  = act_src;
        cap_mask = act_mask;
      end
      total++;
      if (act_vec !== exp_vec || act_ready !== '0 || act_wr_en !== 1'b0 ||
          {act_addr, act_data, act_src, act_mask} !== {cap_addr, cap_data, cap_src, cap_mask}) begin
        bad++;
        $display("FAIL stall_hold c%0d: got %h want %h", c, act_vec, exp_vec);
      end
    end
    v_stall = 1'b0;
    cycle();
    total++;
    if (act_vec !== exp_vec || act_wr_en !== 1'b1 || {act_addr, act_data} !== {cap_addr, cap_data} ||
        onehot_idx(act_ready) != (int'(cap_src) + 1) % N) begin
      bad++;
      $display("FAIL stall_release: got %h want %h (grant %0d)", act_vec, exp_vec, (int'(cap_src) + 1) % N);
    end
    renew();
  endtask

  task automatic test_wrap();
    v_valid = '0;
    repeat (2) cycle();
    v_valid   = 4'b0100;
    v_addr[2] = 4'd6;
    v_data[2] = $urandom;
    cycle();
    renew();
    v_valid   = 4'b0101;
    v_addr[0] = 4'd1;
    v_data[0] = $urandom;
    cycle();
    total++;
    if (act_ready !== 4'b0001 || act_vec !== exp_vec) begin
      bad++;
      $display("FAIL wrap_req0: got %b want 0001", act_ready);
    end
    renew();
    cycle();
    total++;
    if (act_ready !== 4'b0100 || act_vec !== exp_vec) begin
      bad++;
      $display("FAIL wrap_req2: got %b want 0100", act_ready);
    end
    v_valid = '0;
    repeat (2) cycle();
  endtask

  task automatic test_same_addr();
    int base = dut_log_src.size();
    v_valid   = 4'b0001;
    v_addr[0] = 4'd5;
    v_data[0] = 32'h11;
    cycle();
    v_valid   = 4'b1000;
    v_addr[3] = 4'd5;
    v_data[3] = 32'h22;
    cycle();
    v_valid = '0;
    repeat (2) cycle();
    total++;
    if (dut_log_src.size() != base + 2 ||
        dut_log_src[base] != 0 || dut_log_src[base+1] != 3 ||
        dut_log_data[base] !== 32'h11 || dut_log_data[base+1] !== 32'h22) begin
      bad++;
      $display("FAIL same_addr_order: got %0d writes want 2 (src 0 then 3, data 11 then 22)",
               dut_log_src.size() - base);
    end
    total++;
    if (dut_rf[5] !== 32'h22 || m_rf[5] !== 32'h22) begin
      bad++;
      $display("FAIL same_addr_final: got %h want 00000022", dut_rf[5]);
    end
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] rf9_before = dut_rf[9];
    v_stall   = 1'b1;
    v_valid   = 4'b0010;
    v_addr[1] = 4'd9;
    v_data[1] = 32'hCAFE0009;
    cycle();
    v_valid = '0;
    cycle();
    total++;
    if (act_wr_en !== 1'b0 || act_mask !== 16'h0200 || act_vec !== exp_vec) begin
      bad++;
      $display("FAIL mid_full: got en=%b mask=%h want en=0 mask=0200", act_wr_en, act_mask);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++;
    if (wr_en !== 1'b0 || pending_mask !== '0) begin
      bad++;
      $display("FAIL mid_reset: got en=%b mask=%h want en=0 mask=0000", wr_en, pending_mask);
    end
    model_reset();
    @(negedge clk);
    rst_n   = 1'b1;
    v_stall = 1'b0;
    v_valid = '1;
    for (int k = 0; k < N; k++) v_addr[k] = 4'd2;
    cycle();
    total++;
    if (act_ready !== 4'b0001 || act_wr_en !== 1'b0 || act_vec !== exp_vec) begin
      bad++;
      $display("FAIL mid_priority: got ready=%b en=%b want ready=0001 en=0", act_ready, act_wr_en);
    end
    v_valid = '0;
    repeat (2) cycle();
    total++;
    if (dut_rf[9] !== rf9_before) begin
      bad++;
      $display("FAIL mid_discard: got %h want %h", dut_rf[9], rf9_before);
    end
  endtask

  task automatic test_random();
    v_valid = '0;
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < N; k++) begin
        if (!v_valid[k] && $urandom_range(0, 2) == 0) begin
          v_valid[k] = 1'b1;
          v_addr[k]  = AW'($urandom_range(0, NR - 1));
          v_data[k]  = $urandom;
        end
      end
      v_stall = ($urandom_range(0, 3) == 0);
      cycle();
      total++;
      if (act_vec !== exp_vec) begin
        bad++;
        $display("FAIL random c%0d: got %h want %h", c, act_vec, exp_vec);
      end
      v_valid = v_valid & ~hs_mask;
    end
    v_valid = '0;
    v_stall = 1'b0;
    repeat (3) cycle();
    for (int r = 0; r < NR; r++) begin
      total++;
      if (dut_rf[r] !== m_rf[r]) begin
        bad++;
        $display("FAIL random_rf r%0d: got %h want %h", r, dut_rf[r], m_rf[r]);
      end
    end
  endtask

  initial begin
    for (int r = 0; r < NR; r++) begin
      m_rf[r]   = '0;
      dut_rf[r] = '0;
    end
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_wrap();
    test_same_addr();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got no completion want completion");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
